// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer
// Byte-stream front end for the 8-op combinational ALU. It collects the A, B and
// OP bytes, holds them steady on the ALU inputs, and captures the ALU result in a
// single execute cycle. It then streams the response back over a valid/ready
// byte interface.
//
// Build option: define ALU_SEQ_FLAGS_EN to send a second response byte that
// carries the ALU flags, {3'b0, neg, zero, overflow, borrow, carry}. Without the
// macro each command returns only the result byte, and the flag registers are
// not built.
module alu_byte_sequencer #(
  parameter int W       = 8,
  parameter int WOP     = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic           rx_ready,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [WOP-1:0] alu_op,
  input  logic [W-1:0]   alu_y,
  input  logic           alu_carry,
  input  logic           alu_borrow,
  input  logic           alu_overflow,
  input  logic           alu_zero,
  input  logic           alu_neg,
  output logic           busy
);

  // The idle counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] IDLE_LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    SEND_Y
`ifdef ALU_SEQ_FLAGS_EN
    ,
    SEND_F
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] idle_cnt;
  logic          rx_fire;
  logic          tx_fire;

`ifdef ALU_SEQ_FLAGS_EN
  logic [4:0]    flags_q;
`endif

  // The upper opcode bits are discarded on purpose.
  // Without the flag byte, the ALU flags are not used either.
  logic          unused_bits;
`ifdef ALU_SEQ_FLAGS_EN
  assign unused_bits = ^rx_data[7:WOP];
`else
  assign unused_bits = ^{rx_data[7:WOP], alu_carry, alu_borrow, alu_overflow,
                         alu_zero, alu_neg};
`endif

  // A byte moves only on an edge where both valid and ready are high.
  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;

  // Command sequencer: operand capture, idle timeout, execute and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GET_A;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      idle_cnt <= '0;
      rx_ready <= 1'b1;
      busy     <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      case (state)
        GET_A: begin
          if (rx_fire) begin
            alu_a    <= rx_data[W-1:0];
            idle_cnt <= '0;
            busy     <= 1'b1;
            state    <= GET_B;
          end
        end

        GET_B: begin
          if (rx_fire) begin
            alu_b    <= rx_data[W-1:0];
            idle_cnt <= '0;
            state    <= GET_OP;
          end else if (idle_cnt == IDLE_LIMIT) begin
            idle_cnt <= '0;
            busy     <= 1'b0;
            state    <= GET_A;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        GET_OP: begin
          if (rx_fire) begin
            alu_op   <= rx_data[WOP-1:0];
            idle_cnt <= '0;
            rx_ready <= 1'b0;
            state    <= EXEC;
          end else if (idle_cnt == IDLE_LIMIT) begin
            idle_cnt <= '0;
            busy     <= 1'b0;
            state    <= GET_A;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        EXEC: begin
          tx_data  <= alu_y;
          tx_valid <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
          flags_q  <= {alu_neg, alu_zero, alu_overflow, alu_borrow, alu_carry};
`endif
          state    <= SEND_Y;
        end

        SEND_Y: begin
          if (tx_fire) begin
`ifdef ALU_SEQ_FLAGS_EN
            tx_data  <= {3'b000, flags_q};
            state    <= SEND_F;
`else
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= GET_A;
`endif
          end
        end

`ifdef ALU_SEQ_FLAGS_EN
        SEND_F: begin
          if (tx_fire) begin
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= GET_A;
          end
        end
`endif

        default: begin
          tx_valid <= 1'b0;
          rx_ready <= 1'b1;
          busy     <= 1'b0;
          idle_cnt <= '0;
          state    <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// tb_alu_byte_sequencer
// Drives directed and random commands through alu_byte_sequencer. A behavioural
// ALU stands in for the real one, and the expected responses come from the
// bytes the bench sends.
module tb_alu_byte_sequencer;

  localparam int TMO = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_y;
  logic       alu_carry;
  logic       alu_borrow;
  logic       alu_overflow;
  logic       alu_zero;
  logic       alu_neg;
  logic       busy;

  int checks = 0;
  int errors = 0;

  alu_byte_sequencer #(.W(8), .WOP(6), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_y(alu_y),
    .alu_carry(alu_carry),
    .alu_borrow(alu_borrow),
    .alu_overflow(alu_overflow),
    .alu_zero(alu_zero),
    .alu_neg(alu_neg),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour: returns {neg, zero, overflow, borrow, carry, y}.
  function automatic logic [12:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
    logic [8:0] wide;
    logic [7:0] y;
    logic c, br, ov;
    c = 1'b0; br = 1'b0; ov = 1'b0; y = 8'h00;
    case (op)
      6'h20: begin
        wide = {1'b0, a} + {1'b0, b};
        y = wide[7:0]; c = wide[8];
        ov = (a[7] == b[7]) && (y[7] != a[7]);
      end
      6'h22: begin
        y = a - b; br = (a < b);
        ov = (a[7] != b[7]) && (y[7] != a[7]);
      end
      6'h03: y = $signed(a) >>> b[2:0];
      6'h24: y = a & b;
      6'h25: y = a | b;
      6'h26: y = a ^ b;
      6'h01: y = a >> b[2:0];
      6'h00: y = a << b[2:0];
      default: y = 8'h00;
    endcase
    return {y[7], (y == 8'h00), ov, br, c, y};
  endfunction

  // Combinational ALU stand-in connected to the sequencer's registered operands.
  always_comb begin
    logic [12:0] r;
    r = alu_model(alu_a, alu_b, alu_op);
    alu_y        = r[7:0];
    alu_carry    = r[8];
    alu_borrow   = r[9];
    alu_overflow = r[10];
    alu_zero     = r[11];
    alu_neg      = r[12];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte, starting from #1 after an edge.
  // Returns #1 after the edge on which the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) check("rx_ready_wait", 32'd0, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Called right after the OP byte was accepted.
  // Checks EXEC latency, holding under backpressure, and the response bytes.
  task automatic expect_response(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] op, input int stall);
    logic [12:0] r;
    r = alu_model(a, b, op[5:0]);
    check("exec_tx_valid", tx_valid, 0);
    check("exec_rx_ready", rx_ready, 0);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_op", alu_op, op[5:0]);
    @(posedge clk); #1;
    check("y_valid", tx_valid, 1);
    check("y_data", tx_data, r[7:0]);
    for (int i = 0; i < stall; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      @(posedge clk); #1;
      check("hold_valid", tx_valid, 1);
      check("hold_data", tx_data, r[7:0]);
      check("hold_rx_ready", rx_ready, 0);
      check("hold_alu_a", alu_a, a);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
    check("f_valid", tx_valid, 1);
    check("f_data", tx_data, {3'b000, r[12:8]});
    check("f_busy", busy, 1);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
`endif
    check("done_tx_valid", tx_valid, 0);
    check("done_busy", busy, 0);
    check("done_rx_ready", rx_ready, 1);
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input int stall);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    expect_response(a, b, op, stall);
  endtask

  initial begin
    logic [5:0] ops [10];
    logic [7:0] ra, rb, rop;
    logic [1:0] hi;
    ops = '{6'h20, 6'h22, 6'h03, 6'h24, 6'h25, 6'h26, 6'h01, 6'h00, 6'h3F, 6'h15};

    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    #12;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_op, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_rx_ready", rx_ready, 1);

    $display("[TB] directed commands");
    run_cmd(8'h7F, 8'h01, 8'h20, 0);
    run_cmd(8'h05, 8'h07, 8'h22, 0);
    run_cmd(8'hFF, 8'h01, 8'h20, 1);
    run_cmd(8'h80, 8'h02, 8'h03, 0);
    run_cmd(8'h12, 8'h34, 8'hE0, 0);
    run_cmd(8'h12, 8'h34, 8'h3F, 0);

    $display("[TB] backpressure");
    run_cmd(8'h7F, 8'h01, 8'h20, 5);

    $display("[TB] timeout");
    send_byte(8'h11);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    check("tmo_not_yet", busy, 1);
    @(posedge clk); #1;
    check("tmo_busy", busy, 0);
    check("tmo_rx_ready", rx_ready, 1);
    check("tmo_alu_a_kept", alu_a, 8'h11);
    run_cmd(8'h02, 8'h03, 8'h20, 0);

    $display("[TB] transfer on expiry cycle");
    send_byte(8'h11);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    send_byte(8'h22);
    check("expiry_busy", busy, 1);
    check("expiry_alu_b", alu_b, 8'h22);
    send_byte(8'h20);
    expect_response(8'h11, 8'h22, 8'h20, 0);

    $display("[TB] reset mid-operation");
    send_byte(8'h40);
    send_byte(8'h41);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h09);
    send_byte(8'h04);
    send_byte(8'h22);
    @(posedge clk); #1;
    check("pend_tx_valid", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    check("drop_tx_valid", tx_valid, 0);
    check("drop_tx_data", tx_data, 0);
    check("drop_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] random commands");
    for (int k = 0; k < 25; k++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      hi  = 2'($urandom_range(0, 3));
      rop = {hi, ops[$urandom_range(0, 9)]};
      run_cmd(ra, rb, rop, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so that a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
